// File: rtl/seq_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [3:0] DEF_PAT = 4'b0110;
    localparam logic [2:0] DEF_LEN = 3'd4;

    localparam int unsigned PAT_W_DEF = 4;
    localparam int unsigned LEN_W_DEF = 3;
    localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/seq_shift_match.sv
// Serial history register, fill counter and variable-length pattern compare.
// hit is combinational on the bit being accepted this cycle.
module seq_shift_match
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             overlap,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

    logic [PAT_W-1:0] hist_q, hist_d, mask;
    logic [LEN_W-1:0] fill_q, fill_inc;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hist_d   = {hist_q[PAT_W-2:0], x};
        fill_inc = (fill_q == FULL) ? FULL : fill_q + LEN_W'(1);
        hit      = shift_en && (fill_inc >= len) && ((hist_d & mask) == (pattern & mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_d;
            // Non-overlapping mode restarts the fill so no bits are shared
            fill_q <= (hit && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Configure-and-sequence wrapper: IDLE/RUN control, saturating match counter
// and a valid/ack match event with sticky overflow.
module seq_match_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             stop,
    input  logic             x,
    input  logic             x_valid,
    output logic             busy,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             evt_valid,
    input  logic             evt_ack,
    output logic             evt_overflow
);

    localparam logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] RST_LEN = (PAT_W < 4) ? MAX_LEN : LEN_W'(DEF_LEN);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q, len_clamped;
    logic             ovl_q;
    logic             z_q;
    logic [CNT_W-1:0] cnt_q;
    logic             evt_valid_q, evt_ovf_q;
    logic             start_edge, accept, hit;

    always_comb begin
        state_d    = state_q;
        start_edge = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_RUN;
                    start_edge = 1'b1;
                end
            end
            ST_RUN: begin
                accept = x_valid;
                if (stop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        len_clamped = (cfg_len == '0 || cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
    end

    seq_shift_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shift_match (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .clr      (start_edge),
        .overlap  (ovl_q),
        .x        (x),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= RST_PAT;
            len_q   <= RST_LEN;
            ovl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (cfg_we && state_q == ST_IDLE) begin
                pat_q <= cfg_pattern;
                len_q <= len_clamped;
                ovl_q <= cfg_overlap;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q         <= 1'b0;
            cnt_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ovf_q   <= 1'b0;
        end else begin
            z_q <= hit;
            if (start_edge) begin
                cnt_q     <= '0;
                evt_ovf_q <= 1'b0;
            end else if (hit) begin
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                // A match acked in the same cycle replaces the old event cleanly
                if (evt_valid_q && !evt_ack) evt_ovf_q <= 1'b1;
            end
            if (hit) begin
                evt_valid_q <= 1'b1;
            end else if (evt_ack && evt_valid_q) begin
                evt_valid_q <= 1'b0;
            end
        end
    end

    assign busy         = (state_q == ST_RUN);
    assign z            = z_q;
    assign match_count  = cnt_q;
    assign evt_valid    = evt_valid_q;
    assign evt_overflow = evt_ovf_q;

endmodule
